// File: rtl/cpu_types_pkg.sv
// rtl/cpu_types_pkg.sv - shared pipeline types
package cpu_types_pkg;

    typedef logic [4:0] regbits_t;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        DWAIT  = 2'd1,
        DRAIN  = 2'd2,
        HALTED = 2'd3
    } hcu_state_t;

endpackage

// File: rtl/hazard_detect.sv
// rtl/hazard_detect.sv - load-use dependency comparator between EX load and ID sources
module hazard_detect
    import cpu_types_pkg::*;
(
    input  regbits_t ifid_rs,
    input  regbits_t ifid_rt,
    input  regbits_t idex_rt,
    input  logic     idex_dREN,
    output logic     lduse
);

    // $zero never carries a real dependency, so a load into it cannot stall
    assign lduse = idex_dREN && (idex_rt != '0) &&
                   ((idex_rt == ifid_rs) || (idex_rt == ifid_rt));

endmodule

// File: rtl/hazard_control_unit.sv
// rtl/hazard_control_unit.sv - pipeline stall/flush sequencer with halt drain and perf counters
module hazard_control_unit
    import cpu_types_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             CLK,
    input  logic             nRST,
    input  logic             ihit,
    input  logic             dhit,
    input  regbits_t         ifid_rs,
    input  regbits_t         ifid_rt,
    input  regbits_t         idex_rt,
    input  logic             idex_dREN,
    input  logic             exmem_dREN,
    input  logic             exmem_dWEN,
    input  logic             redirect,
    input  logic             exmem_halt,
    output logic             pc_en,
    output logic             ifid_en,
    output logic             idex_en,
    output logic             exmem_en,
    output logic             memwb_en,
    output logic             ifid_flush,
    output logic             idex_flush,
    output logic             halted,
    output logic [CNT_W-1:0] stall_count,
    output logic [CNT_W-1:0] flush_count
);

    hcu_state_t       state, next_state;
    logic             ihit_pend;
    logic [CNT_W-1:0] stall_cnt, flush_cnt;

    logic lduse, mem_busy, fetch_ok;
    logic c_pc, c_ifid, c_idex, c_exmem, c_memwb, c_fifid, c_fidex;
    logic take_redirect, pend_hold, stall_inc;

    hazard_detect u_hazard_detect (
        .ifid_rs   (ifid_rs),
        .ifid_rt   (ifid_rt),
        .idex_rt   (idex_rt),
        .idex_dREN (idex_dREN),
        .lduse     (lduse)
    );

    assign mem_busy = (exmem_dREN || exmem_dWEN) && !dhit;
    assign fetch_ok = ihit || ihit_pend;

    always_comb begin
        c_pc          = 1'b0;
        c_ifid        = 1'b0;
        c_idex        = 1'b0;
        c_exmem       = 1'b0;
        c_memwb       = 1'b0;
        c_fifid       = 1'b0;
        c_fidex       = 1'b0;
        take_redirect = 1'b0;
        pend_hold     = 1'b0;
        stall_inc     = 1'b0;
        next_state    = state;
        case (state)
            RUN, DWAIT: begin
                next_state = RUN;
                if (exmem_halt && !mem_busy) begin
                    c_fidex    = 1'b1;
                    c_memwb    = 1'b1;
                    next_state = DRAIN;
                end else if (mem_busy) begin
                    pend_hold  = 1'b1;
                    next_state = DWAIT;
                end else if (redirect) begin
                    {c_pc, c_ifid, c_idex, c_exmem, c_memwb} = '1;
                    c_fifid       = 1'b1;
                    c_fidex       = 1'b1;
                    take_redirect = 1'b1;
                end else if (lduse || !fetch_ok) begin
                    c_fidex   = 1'b1;
                    c_exmem   = 1'b1;
                    c_memwb   = 1'b1;
                    pend_hold = lduse;
                end else begin
                    {c_pc, c_ifid, c_idex, c_exmem, c_memwb} = '1;
                end
                stall_inc = !c_pc;
            end
            DRAIN:   next_state = HALTED;
            default: next_state = HALTED;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            state     <= RUN;
            ihit_pend <= 1'b0;
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            state <= next_state;
            // a word fetched while the front end is frozen is remembered until the PC advances
            if (c_pc || take_redirect) begin
                ihit_pend <= 1'b0;
            end else if (ihit && pend_hold) begin
                ihit_pend <= 1'b1;
            end
            if (stall_inc && (stall_cnt != '1)) begin
                stall_cnt <= stall_cnt + CNT_W'(1);
            end
            if (take_redirect && (flush_cnt != '1)) begin
                flush_cnt <= flush_cnt + CNT_W'(1);
            end
        end
    end

    // everything reads as zero while reset is held, independent of the registered state
    assign pc_en       = nRST && c_pc;
    assign ifid_en     = nRST && c_ifid;
    assign idex_en     = nRST && c_idex;
    assign exmem_en    = nRST && c_exmem;
    assign memwb_en    = nRST && c_memwb;
    assign ifid_flush  = nRST && c_fifid;
    assign idex_flush  = nRST && c_fidex;
    assign halted      = nRST && (state == HALTED);
    assign stall_count = nRST ? stall_cnt : '0;
    assign flush_count = nRST ? flush_cnt : '0;

endmodule
